// File: rtl/softmax.sv
// softmax -- pipelined fixed-point softmax over N signed Q4.12 elements.
// Each element is shifted by the caller-supplied maximum and passed through
// a base-2 exponent (integer shift plus linear mantissa). The results are
// summed and each one is divided exactly by the sum, giving unsigned Q4.12
// probabilities.
// Optional macro SOFTMAX_PIPE_EN registers the exponents and their sum
// before the divide. Latency is 2 with the macro and 1 without it. The
// numerical results are the same in both builds.
module softmax #(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [N*16-1:0] in_x_flat,
  input  logic [15:0]     max_x,
  output logic            out_valid,
  output logic [N*16-1:0] prob_flat
);

  // The sum of N exponents, each at most 4096, fits in 16 + clog2(N) bits.
  localparam int SW = 16 + $clog2(N);
  // The dividend is e << 12, which is 28 bits wide, so widen the divider to cover both operands.
  localparam int DW = (SW > 28) ? SW : 28;

  // 2^(log2(e) * d) in Q4.12 for d = x - max clamped to <= 0.
  function automatic logic [15:0] exp_q12(input logic [15:0] x, input logic [15:0] m);
    logic signed [16:0] d;
    logic signed [31:0] t;
    logic signed [31:0] ip;
    logic [31:0]        sh;
    logic [15:0]        base;
    d = $signed({x[15], x}) - $signed({m[15], m});
    // A positive difference only happens when the caller's max is wrong. Treat it as exp(0).
    if (!d[16]) d = '0;
    // |d| * 5909 < 2^31, so the product cannot overflow 32 bits. >>> gives floor.
    t    = ($signed({{15{d[16]}}, d}) * 32'sd5909) >>> 12;
    ip   = t >>> 12;
    sh   = $unsigned(-ip);
    base = 16'd4096 + {4'd0, t[11:0]};
    if (sh >= 32'd16) return '0;
    return base >> sh[3:0];
  endfunction

  // floor(e * 4096 / s), forced to zero when every exponent underflowed.
  function automatic logic [15:0] div_q12(input logic [15:0] e, input logic [SW-1:0] s);
    logic [DW-1:0] num;
    if (s == '0) return '0;
    num = DW'({e, 12'd0});
    return 16'(num / DW'(s));
  endfunction

  logic [15:0]     e_d [N];
  logic [SW-1:0]   s_d;
  logic [15:0]     e_b [N];
  logic [SW-1:0]   s_b;
  logic            v_b;
  logic            out_valid_d, out_valid_q;
  logic [N*16-1:0] prob_d, prob_q;

  // Per-element exponent and the running sum for the current input vector.
  // NOTE: every variable assigned here gets a value on every path (s_d is
  // defaulted first), so no latch is inferred.
  always_comb begin
    s_d = '0;
    for (int i = 0; i < N; i++) begin
      e_d[i] = exp_q12(in_x_flat[16*i +: 16], max_x);
      s_d    = s_d + SW'(e_d[i]);
    end
  end

`ifdef SOFTMAX_PIPE_EN
  logic [15:0]   e_q [N];
  logic [SW-1:0] s_q;
  logic          v_q;

  // Register the exponents and their sum so the divide gets a full cycle.
  // NOTE: the data registers are reset along with the valid bit. This is
  // cheap at this size and keeps simulation free of X values after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      s_q <= '0;
      for (int i = 0; i < N; i++) e_q[i] <= '0;
    end else begin
      v_q <= in_valid;
      s_q <= s_d;
      for (int i = 0; i < N; i++) e_q[i] <= e_d[i];
    end
  end

  // The divide stage reads the registered exponents and sum.
  always_comb begin
    v_b = v_q;
    s_b = s_q;
    for (int i = 0; i < N; i++) e_b[i] = e_q[i];
  end
`else
  // The divide stage reads the exponents and sum directly, with no register in between.
  always_comb begin
    v_b = in_valid;
    s_b = s_d;
    for (int i = 0; i < N; i++) e_b[i] = e_d[i];
  end
`endif

  // Normalise each exponent by the sum. Hold the last result when no vector arrives.
  always_comb begin
    out_valid_d = v_b;
    prob_d      = prob_q;
    if (v_b) begin
      for (int i = 0; i < N; i++) prob_d[16*i +: 16] = div_q12(e_b[i], s_b);
    end
  end

  // Output register for the valid flag and the probabilities.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      prob_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      prob_q      <= prob_d;
    end
  end

  assign out_valid = out_valid_q;
  assign prob_flat = prob_q;

endmodule

// File: tb/tb_softmax.sv
// tb_softmax -- directed bench for softmax (N = 4).
// It applies a table of vectors with hand-computed probabilities, then runs
// a back-to-back burst and a reset issued while a vector is in flight.
// The latency follows SOFTMAX_PIPE_EN when that macro is defined for the whole compile.
module tb_softmax;

`ifdef SOFTMAX_PIPE_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in_x_flat;
  logic [15:0] max_x;
  logic        out_valid;
  logic [63:0] prob_flat;

  int tests;
  int fails;

  softmax #(.N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_x_flat (in_x_flat),
    .max_x     (max_x),
    .out_valid (out_valid),
    .prob_flat (prob_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] x;
    logic [15:0] m;
    logic [63:0] p;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one vector on a falling edge. Check that out_valid stays low
  // until the edge L cycles after sampling, then check the result, then
  // check that the result is held once out_valid drops.
  task automatic apply(input string name, input vec_t v);
    in_valid  = 1'b1;
    in_x_flat = v.x;
    max_x     = v.m;
    @(negedge clk);
    in_valid  = 1'b0;
    in_x_flat = '0;
    max_x     = '0;
    for (int j = 1; j < L; j++) begin
      check($sformatf("%s_early", name), {63'd0, out_valid}, 64'd0);
      @(negedge clk);
    end
    check($sformatf("%s_valid", name), {63'd0, out_valid}, 64'd1);
    check($sformatf("%s_prob", name), prob_flat, v.p);
    @(negedge clk);
    check($sformatf("%s_drop", name), {63'd0, out_valid}, 64'd0);
    check($sformatf("%s_hold", name), prob_flat, v.p);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    // Element 0 is in the low 16 bits of each 64-bit word.
    vecs[0] = '{x: 64'h15DB_2771_FE18_EC80, m: 16'h2771, p: 64'h03E0_0AF7_00DE_0049};
    vecs[1] = '{x: 64'h1000_1000_1000_1000, m: 16'h1000, p: 64'h0400_0400_0400_0400};
    vecs[2] = '{x: 64'h8000_8000_8000_0000, m: 16'h0000, p: 64'h0000_0000_0000_0FFD};
    vecs[3] = '{x: 64'h8000_8000_8000_8000, m: 16'h7FFF, p: 64'h0000_0000_0000_0000};
    vecs[4] = '{x: 64'h1000_1000_0000_3000, m: 16'h1000, p: 64'h04B8_04B8_01D6_04B8};
    vecs[5] = '{x: 64'hD000_E000_F000_0000, m: 16'h0000, p: 64'h0087_0168_03F0_0A1F};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x_flat = '0;
    max_x     = '0;
    repeat (2) @(negedge clk);
    check("reset_valid", {63'd0, out_valid}, 64'd0);
    check("reset_prob", prob_flat, 64'd0);
    rst_n = 1'b1;

    // The first vector after reset release exercises the exact latency.
    for (int i = 0; i < 6; i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Three vectors back to back must come out on consecutive cycles, in order.
    for (int c = 0; c < L + 4; c++) begin
      if (c >= L && c - L < 3) begin
        check($sformatf("b2b%0d_valid", c - L), {63'd0, out_valid}, 64'd1);
        check($sformatf("b2b%0d_prob", c - L), prob_flat, vecs[c - L].p);
      end else if (c > 0) begin
        check($sformatf("b2b_idle%0d", c), {63'd0, out_valid}, 64'd0);
      end
      if (c < 3) begin
        in_valid  = 1'b1;
        in_x_flat = vecs[c].x;
        max_x     = vecs[c].m;
      end else begin
        in_valid  = 1'b0;
      end
      @(negedge clk);
    end

    // Assert reset after a vector has been sampled. The outputs must clear at
    // once, and the vector must never come out.
    in_valid  = 1'b1;
    in_x_flat = vecs[4].x;
    max_x     = vecs[4].m;
    @(negedge clk);
    in_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    check("rst_async_valid", {63'd0, out_valid}, 64'd0);
    check("rst_async_prob", prob_flat, 64'd0);
    repeat (2) @(negedge clk);
    check("rst_hold_valid", {63'd0, out_valid}, 64'd0);
    check("rst_hold_prob", prob_flat, 64'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int j = 0; j < L + 1; j++) begin
      @(negedge clk);
      check($sformatf("rst_discard%0d", j), {63'd0, out_valid}, 64'd0);
    end
    apply("post_reset", vecs[5]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
